branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the 5-stage RV32I pipeline.
- Combines a direct-mapped branch target buffer (BTB) with a table of 2-bit saturating counters.
- Lookup happens in IF on the fetch address. Training happens from the MEM stage, where branches and jumps resolve today.
- Turns the current fixed "predict not-taken, flush IF/ID/EX on taken" policy into speculative fetch. It also generates the mispredict/redirect signal that drives pcsrc and the flushes.

---
 rtl/branch_predictor_pkg.sv | 28 ++
 rtl/bp_sat_counter.sv | 29 ++
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_predictor_pkg : counter encodings and default geometry for the BTB.
// Rev 1.0
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

  localparam int BP_PC_WIDTH   = 32;
  localparam int BP_ENTRIES    = 64;
  localparam int BP_TAG_WIDTH  = 10;
  localparam int BP_GHR_WIDTH  = 6;

  // pc[1:0] never reach the index; the index starts at bit 2.
  localparam int BP_IDX_LSB    = 2;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT = 2'b00;
  localparam cnt_t CNT_WNT = 2'b01;
  localparam cnt_t CNT_WT  = 2'b10;
  localparam cnt_t CNT_ST  = 2'b11;

  function automatic int idx_width(input int entries);
    return $clog2(entries);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bp_sat_counter : 2-bit saturating counter next-state with inc/dec/force.
// Rev 1.0
// ---------------------------------------------------------------------------
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  cnt_t cnt,
  input  logic inc,
  input  logic dec,
  input  logic force_en,
  input  cnt_t force_val,
  output cnt_t next
);

  always_comb begin
    next = cnt;
    if (force_en) begin
      next = force_val;
    end else if (inc && (cnt != CNT_ST)) begin
      next = cnt + 2'd1;
    end else if (dec && (cnt != CNT_SNT)) begin
      next = cnt - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_predictor : direct-mapped BTB + 2-bit counters, lookup in IF, train
// from MEM. Optional gshare counter indexing under BP_GSHARE_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PC_WIDTH  = BP_PC_WIDTH,
  parameter int ENTRIES   = BP_ENTRIES,
  parameter int TAG_WIDTH = BP_TAG_WIDTH,
  parameter int GHR_WIDTH = BP_GHR_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] if_pc,
  output logic                if_pred_taken,
  output logic [PC_WIDTH-1:0] if_pred_target,
  input  logic                mem_valid,
  input  logic                mem_is_jump,
  input  logic [PC_WIDTH-1:0] mem_pc,
  input  logic                mem_taken,
  input  logic [PC_WIDTH-1:0] mem_target,
  input  logic                mem_pred_taken,
  input  logic [PC_WIDTH-1:0] mem_pred_target,
  output logic                mispredict,
  output logic [PC_WIDTH-1:0] redirect_pc
);

  localparam int IDX_W   = idx_width(ENTRIES);
  localparam int IDX_MSB = BP_IDX_LSB + IDX_W - 1;
  localparam int TAG_LSB = IDX_MSB + 1;
  localparam int TAG_MSB = TAG_LSB + TAG_WIDTH - 1;

  logic                valid_q  [ENTRIES];
  logic [TAG_WIDTH-1:0] tag_q   [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  cnt_t                cnt_q    [ENTRIES];

  logic [IDX_W-1:0]     if_idx, mem_idx, if_cidx, mem_cidx;
  logic [TAG_WIDTH-1:0] if_tag, mem_tag;
  logic                 if_hit, mem_hit, mem_alloc;
  cnt_t                 cnt_next;
  logic                 unused_pc;

  assign if_idx  = if_pc[IDX_MSB:BP_IDX_LSB];
  assign if_tag  = if_pc[TAG_MSB:TAG_LSB];
  assign mem_idx = mem_pc[IDX_MSB:BP_IDX_LSB];
  assign mem_tag = mem_pc[TAG_MSB:TAG_LSB];

  assign unused_pc = ^{if_pc, mem_pc};

`ifdef BP_GSHARE_EN
  logic [GHR_WIDTH-1:0] ghr_q;

  // History advances only at resolution, so IF sees the committed history.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (mem_valid && !mem_is_jump) begin
      ghr_q <= {ghr_q[GHR_WIDTH-2:0], mem_taken};
    end
  end

  assign if_cidx  = if_idx  ^ IDX_W'(ghr_q);
  assign mem_cidx = mem_idx ^ IDX_W'(ghr_q);
`else
  logic [GHR_WIDTH-1:0] unused_ghr;
  assign unused_ghr = '0;
  assign if_cidx    = if_idx;
  assign mem_cidx   = mem_idx;
`endif

  // Lookup reads the registered tables, which gives read-old on collisions.
  assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_pred_taken  = !rst && if_hit && cnt_q[if_cidx][1];
  assign if_pred_target = if_pred_taken ? target_q[if_idx] : if_pc + PC_WIDTH'(4);

  assign mem_hit   = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);
  assign mem_alloc = mem_taken || mem_hit || mem_is_jump;

  bp_sat_counter u_sat_counter (
    .cnt       (cnt_q[mem_cidx]),
    .inc       (mem_hit && mem_taken),
    .dec       (mem_hit && !mem_taken),
    .force_en  (mem_is_jump || !mem_hit),
    .force_val (mem_is_jump ? CNT_ST : (mem_taken ? CNT_WT : CNT_WNT)),
    .next      (cnt_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_WNT;
      end
    end else if (mem_valid) begin
      cnt_q[mem_cidx] <= cnt_next;
      if (mem_alloc) begin
        valid_q[mem_idx] <= 1'b1;
        tag_q[mem_idx]   <= mem_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_valid && mem_taken) begin
      target_q[mem_idx] <= mem_target;
    end
  end

  assign mispredict  = !rst && mem_valid &&
                       ((mem_taken != mem_pred_taken) ||
                        (mem_taken && (mem_target != mem_pred_target)));
  assign redirect_pc = !mem_valid ? '0 :
                       (mem_taken ? mem_target : mem_pc + PC_WIDTH'(4));

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_branch_predictor : directed + randomized bench against a table model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int ENT = 64;
  localparam int TW  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        mem_valid, mem_is_jump, mem_taken, mem_pred_taken;
  logic [31:0] mem_pc, mem_target, mem_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_v   [ENT];
  int          m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_cnt [ENT];

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk             (clk),
    .rst             (rst),
    .if_pc           (if_pc),
    .if_pred_taken   (if_pred_taken),
    .if_pred_target  (if_pred_target),
    .mem_valid       (mem_valid),
    .mem_is_jump     (mem_is_jump),
    .mem_pc          (mem_pc),
    .mem_taken       (mem_taken),
    .mem_target      (mem_target),
    .mem_pred_taken  (mem_pred_taken),
    .mem_pred_target (mem_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int f_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic int f_tag(input logic [31:0] pc);
    return int'((pc / (4 * ENT)) % (1 << TW));
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_v[f_idx(pc)] && (m_tag[f_idx(pc)] == f_tag(pc));
  endfunction

  function automatic bit m_pt(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[f_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptg(input logic [31:0] pc);
    return m_pt(pc) ? m_tgt[f_idx(pc)] : pc + 32'd4;
  endfunction

  task automatic model_update();
    int  i;
    bit  hit;
    if (rst) begin
      for (int k = 0; k < ENT; k++) begin
        m_v[k]   = 1'b0;
        m_cnt[k] = 1;
      end
    end else if (mem_valid) begin
      i   = f_idx(mem_pc);
      hit = m_hit(mem_pc);
      if (mem_is_jump)      m_cnt[i] = 3;
      else if (hit)         m_cnt[i] = mem_taken ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                                                 : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
      else                  m_cnt[i] = mem_taken ? 2 : 1;
      if (mem_taken || hit || mem_is_jump) begin
        m_v[i]   = 1'b1;
        m_tag[i] = f_tag(mem_pc);
      end
      if (mem_taken) m_tgt[i] = mem_target;
    end
  endtask

  // Compare all outputs mid-cycle against the model, then advance one clock.
  task automatic step();
    logic        exp_pt, exp_mp;
    logic [31:0] exp_tg, exp_rd;
    @(negedge clk);
    exp_pt = !rst && m_pt(if_pc);
    exp_tg = exp_pt ? m_ptg(if_pc) : if_pc + 32'd4;
    exp_mp = !rst && mem_valid && ((mem_taken != mem_pred_taken) ||
                                   (mem_taken && (mem_target != mem_pred_target)));
    exp_rd = !mem_valid ? 32'd0 : (mem_taken ? mem_target : mem_pc + 32'd4);
    check("pred_taken",  {31'd0, if_pred_taken}, {31'd0, exp_pt});
    check("pred_target", if_pred_target, exp_tg);
    check("mispredict",  {31'd0, mispredict}, {31'd0, exp_mp});
    check("redirect_pc", redirect_pc, exp_rd);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_mem();
    mem_valid = 0; mem_is_jump = 0; mem_taken = 0;
    mem_pc = 0; mem_target = 0; mem_pred_taken = 0; mem_pred_target = 0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic jmp, input logic tk,
                         input logic [31:0] tgt);
    mem_valid = 1; mem_is_jump = jmp; mem_pc = pc; mem_taken = tk; mem_target = tgt;
    mem_pred_taken = m_pt(pc); mem_pred_target = m_ptg(pc);
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 6))
      0:       return 32'h100;
      1:       return 32'h104;
      2:       return 32'h200;
      3:       return 32'h100 + ENT * 4;
      4:       return 32'h1fc;
      5:       return 32'h103;
      default: return $urandom & 32'h0003_fffc;
    endcase
  endfunction

  initial begin
    for (int k = 0; k < ENT; k++) begin
      m_v[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_cnt[k] = 1;
    end
    rst = 1; if_pc = 32'h100; idle_mem();
    step(); step();

    // Reset then lookup
    rst = 0; #1;
    check("rst_pt",  {31'd0, if_pred_taken}, 32'd0);
    check("rst_tgt", if_pred_target, 32'h104);
    check("rst_mp",  {31'd0, mispredict}, 32'd0);
    step();

    // Cold taken branch
    resolve(32'h100, 0, 1, 32'h80); mem_pred_taken = 0; mem_pred_target = 32'h104; #1;
    check("cold_mp",  {31'd0, mispredict}, 32'd1);
    check("cold_rd",  redirect_pc, 32'h80);
    step();
    idle_mem(); #1;
    check("cold_pt",  {31'd0, if_pred_taken}, 32'd1);
    check("cold_tgt", if_pred_target, 32'h80);
    step();

    // Saturation and hysteresis
    repeat (2) begin resolve(32'h100, 0, 1, 32'h80); step(); end
    resolve(32'h100, 0, 0, 32'h80); step();
    idle_mem(); #1;
    check("hyst_nt1", {31'd0, if_pred_taken}, 32'd1);
    resolve(32'h100, 0, 0, 32'h80); step();
    idle_mem(); #1;
    check("hyst_nt2", {31'd0, if_pred_taken}, 32'd0);
    repeat (2) begin resolve(32'h100, 0, 0, 32'h80); step(); end
    resolve(32'h100, 0, 1, 32'h80); step();
    idle_mem(); #1;
    check("sat_floor", {31'd0, if_pred_taken}, 32'd0);

    // Tag alias: same idx, different tag
    repeat (2) begin resolve(32'h100, 0, 1, 32'h80); step(); end
    idle_mem(); if_pc = 32'h100 + ENT * 4; #1;
    check("alias_pt",  {31'd0, if_pred_taken}, 32'd0);
    check("alias_tgt", if_pred_target, 32'h100 + ENT * 4 + 4);
    step();

    // Read-old collision (counter 11 -> 10 -> 01)
    if_pc = 32'h100;
    resolve(32'h100, 0, 0, 32'h80); step();
    resolve(32'h100, 0, 0, 32'h80); #1;
    check("rdold_pre", {31'd0, if_pred_taken}, 32'd1);
    step();
    idle_mem(); #1;
    check("rdold_post", {31'd0, if_pred_taken}, 32'd0);
    step();

    // Jump and target mismatch
    if_pc = 32'h200;
    resolve(32'h200, 1, 1, 32'h300); step();
    idle_mem(); #1;
    check("jal_pt",  {31'd0, if_pred_taken}, 32'd1);
    check("jal_tgt", if_pred_target, 32'h300);
    resolve(32'h200, 1, 1, 32'h340); mem_pred_taken = 1; mem_pred_target = 32'h300; #1;
    check("jal_mp", {31'd0, mispredict}, 32'd1);
    check("jal_rd", redirect_pc, 32'h340);
    step();
    idle_mem(); #1;
    check("jal_newtgt", if_pred_target, 32'h340);
    step();

    // Randomized traffic, including mid-run resets
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 79) == 0);
      if_pc       = pick_pc();
      mem_valid   = ($urandom_range(0, 9) < 7);
      mem_pc      = pick_pc();
      mem_is_jump = ($urandom_range(0, 7) == 0);
      mem_taken   = mem_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
      mem_target  = 32'($urandom_range(0, 255)) * 4;
      if ($urandom_range(0, 1) == 1) begin
        mem_pred_taken  = m_pt(mem_pc);
        mem_pred_target = m_ptg(mem_pc);
      end else begin
        mem_pred_taken  = 1'($urandom_range(0, 1));
        mem_pred_target = 32'($urandom_range(0, 255)) * 4;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
